// File: rtl/pipe_ctrl.sv
// Pipeline control unit: opcode decode, ID/EX -> EX/MEM -> MEM/WB control
// staging, load-use hazard stall, branch flush and memory-wait freeze.
module pipe_ctrl #(
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned ENABLE_IMM = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [REG_W-1:0]     ifid_rs,
  input  logic [REG_W-1:0]     ifid_rt,
  input  logic                 flush,
  input  logic                 mem_wait,
  output logic [ALUOP_W+1:0]   idex_ex,
  output logic [2:0]           exmem_m,
  output logic [1:0]           memwb_wb,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned EX_W = ALUOP_W + 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [EX_W-1:0]  dec_ex;
  logic [2:0]       dec_m;
  logic [1:0]       dec_wb;
  logic             dec_legal;
  logic [1:0]       dec_aluop;
  logic             dec_regdst;
  logic             dec_alusrc;

  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [REG_W-1:0] idex_rt;
  logic [1:0]       exmem_wb;

  logic             stall;
  logic             advance;

  // Opcode decode into EX/M/WB control bundles; unknown opcodes give all zeros
  always_comb begin
    dec_regdst = 1'b0;
    dec_aluop  = 2'b00;
    dec_alusrc = 1'b0;
    dec_m      = 3'b000;
    dec_wb     = 2'b00;
    dec_legal  = 1'b1;
    case (op)
      OP_RTYPE: begin
        dec_regdst = 1'b1;
        dec_aluop  = 2'b10;
        dec_wb     = 2'b10;
      end
      OP_LW: begin
        dec_alusrc = 1'b1;
        dec_m      = 3'b010;
        dec_wb     = 2'b11;
      end
      OP_SW: begin
        dec_alusrc = 1'b1;
        dec_m      = 3'b001;
      end
      OP_BEQ: begin
        dec_aluop  = 2'b01;
        dec_m      = 3'b100;
      end
      OP_ADDI: begin
        if (ENABLE_IMM != 0) begin
          dec_alusrc = 1'b1;
          dec_wb     = 2'b10;
        end else begin
          dec_legal  = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    dec_ex = {dec_regdst, ALUOP_W'(dec_aluop), dec_alusrc};
  end

  // Load-use hazard against the load currently sitting in ID/EX
  assign stall = idex_m[1] & (idex_rt != '0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Flush wins over stall for fetch enables; mem_wait freezes everything
  assign pc_write   = ~(stall | mem_wait) | (flush & ~mem_wait);
  assign ifid_write = pc_write;

  // Ordinary advance of the pipeline (no freeze, no flush)
  assign advance = ~mem_wait & ~flush;

  // Stage registers: hold on mem_wait, squash on flush, bubble on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      exmem_m  <= '0;
      exmem_wb <= '0;
      memwb_wb <= '0;
    end else if (!mem_wait) begin
      memwb_wb <= exmem_wb;
      if (flush) begin
        idex_ex  <= '0;
        idex_m   <= '0;
        idex_wb  <= '0;
        idex_rt  <= '0;
        exmem_m  <= '0;
        exmem_wb <= '0;
      end else begin
        exmem_m  <= idex_m;
        exmem_wb <= idex_wb;
        if (stall) begin
          idex_ex <= '0;
          idex_m  <= '0;
          idex_wb <= '0;
          idex_rt <= '0;
        end else begin
          idex_ex <= dec_ex;
          idex_m  <= dec_m;
          idex_wb <= dec_wb;
          idex_rt <= ifid_rt;
        end
      end
    end
  end

  // Illegal-opcode pulse and saturating load-use bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      illegal_op <= ~dec_legal & ~stall & advance;
      if (stall && advance && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a record-level model.
module tb_pipe_ctrl;

  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned EN_IMM  = 0;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned EX_W    = ALUOP_W + 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [5:0]         op;
  logic [REG_W-1:0]   ifid_rs, ifid_rt;
  logic               flush, mem_wait;
  logic [EX_W-1:0]    idex_ex;
  logic [2:0]         exmem_m;
  logic [1:0]         memwb_wb;
  logic               pc_write, ifid_write, illegal_op;
  logic [CNT_W-1:0]   stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.ALUOP_W(ALUOP_W), .REG_W(REG_W), .ENABLE_IMM(EN_IMM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .flush(flush), .mem_wait(mem_wait), .idex_ex(idex_ex), .exmem_m(exmem_m),
    .memwb_wb(memwb_wb), .pc_write(pc_write), .ifid_write(ifid_write),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // One in-flight instruction as seen by the control pipeline
  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [2:0]       m;
    logic [1:0]       wb;
    logic [REG_W-1:0] rt;
  } rec_t;

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'o00) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || ((o == 6'b001000) && (EN_IMM != 0));
  endfunction

  // Table lookup: regdst, aluop code, alusrc, M, WB
  function automatic rec_t decode(input logic [5:0] o, input logic [REG_W-1:0] rt);
    rec_t r;
    int regdst, aluop, alusrc;
    r = '0;
    regdst = 0; aluop = 0; alusrc = 0;
    case (o)
      6'b000000: begin regdst = 1; aluop = 2; r.wb = 2'b10; end
      6'b100011: begin alusrc = 1; r.m = 3'b010; r.wb = 2'b11; end
      6'b101011: begin alusrc = 1; r.m = 3'b001; end
      6'b000100: begin aluop = 1; r.m = 3'b100; end
      6'b001000: if (EN_IMM != 0) begin alusrc = 1; r.wb = 2'b10; end
      default: ;
    endcase
    r.ex = EX_W'(regdst * (1 << (ALUOP_W + 1)) + aluop * 2 + alusrc);
    r.rt = rt;
    return r;
  endfunction

  function automatic bit hazard(input rec_t r, input logic [REG_W-1:0] rs,
                                input logic [REG_W-1:0] rt);
    return r.m[1] && (r.rt != 0) && (r.rt == rs || r.rt == rt);
  endfunction

  // Model state
  rec_t m_idex, m_exmem, m_memwb;
  bit   m_ill;
  int   m_cnt;

  // Record-level pipeline model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idex  <= '0;
      m_exmem <= '0;
      m_memwb <= '0;
      m_ill   <= 1'b0;
      m_cnt   <= 0;
    end else if (mem_wait) begin
      m_ill <= 1'b0;
    end else if (flush) begin
      m_idex  <= '0;
      m_exmem <= '0;
      m_memwb <= m_exmem;
      m_ill   <= 1'b0;
    end else begin
      m_idex  <= hazard(m_idex, ifid_rs, ifid_rt) ? '0 : decode(op, ifid_rt);
      m_exmem <= m_idex;
      m_memwb <= m_exmem;
      m_ill   <= !is_legal(op) && !hazard(m_idex, ifid_rs, ifid_rt);
      if (hazard(m_idex, ifid_rs, ifid_rt) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    bit exp_pcw;
    exp_pcw = mem_wait ? 1'b0 : (flush ? 1'b1 : !hazard(m_idex, ifid_rs, ifid_rt));
    chk("model idex_ex",    int'(idex_ex),    int'(m_idex.ex));
    chk("model exmem_m",    int'(exmem_m),    int'(m_exmem.m));
    chk("model memwb_wb",   int'(memwb_wb),   int'(m_memwb.wb));
    chk("model pc_write",   int'(pc_write),   int'(exp_pcw));
    chk("model ifid_write", int'(ifid_write), int'(exp_pcw));
    chk("model illegal_op", int'(illegal_op), int'(m_ill));
    chk("model stall_cnt",  int'(stall_cnt),  m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input int rs, input int rt,
                       input bit fl, input bit mw);
    op = o;
    ifid_rs = REG_W'(rs);
    ifid_rt = REG_W'(rt);
    flush = fl;
    mem_wait = mw;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(6'b000000, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;

  initial begin
    rst_n = 1'b0;
    drive(R, 0, 0, 0, 0);
    #2;
    chk("reset stall_cnt", int'(stall_cnt), 0);
    chk("reset pc_write", int'(pc_write), 1);
    chk("reset idex_ex", int'(idex_ex), 0);
    do_reset();

    // Load-use stall
    drive(LW, 0, 3, 0, 0);
    tick();
    drive(R, 3, 1, 0, 0);
    chk("lu pc_write low", int'(pc_write), 0);
    chk("lu idex lw", int'(idex_ex), 5'b00001);
    chk("lu cnt before", int'(stall_cnt), 0);
    tick();
    chk("lu bubble", int'(idex_ex), 0);
    chk("lu cnt after", int'(stall_cnt), 1);
    chk("lu pc_write back", int'(pc_write), 1);
    chk("lu exmem lw", int'(exmem_m), 3'b010);
    tick();
    chk("lu memwb lw", int'(memwb_wb), 2'b11);
    chk("lu idex rtype", int'(idex_ex), 5'b10100);

    // Load to r0: no hazard
    do_reset();
    drive(LW, 0, 0, 0, 0);
    tick();
    drive(R, 0, 0, 0, 0);
    chk("r0 pc_write", int'(pc_write), 1);
    tick();
    chk("r0 cnt", int'(stall_cnt), 0);
    chk("r0 idex rtype", int'(idex_ex), 5'b10100);

    // Flush squashes younger, keeps older writeback
    do_reset();
    drive(LW, 0, 5, 0, 0);
    tick();
    drive(BEQ, 1, 2, 0, 0);
    tick();
    chk("fl idex beq", int'(idex_ex), 5'b00010);
    drive(R, 0, 0, 1, 0);
    chk("fl pc_write", int'(pc_write), 1);
    tick();
    drive(R, 0, 0, 0, 0);
    chk("fl idex zero", int'(idex_ex), 0);
    chk("fl exmem zero", int'(exmem_m), 0);
    chk("fl memwb kept", int'(memwb_wb), 2'b11);

    // mem_wait freeze
    do_reset();
    drive(LW, 0, 4, 0, 0);
    tick();
    drive(SW, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mw pc_write", int'(pc_write), 0);
      tick();
      chk("mw idex held", int'(idex_ex), 5'b00001);
      chk("mw exmem held", int'(exmem_m), 0);
      chk("mw memwb held", int'(memwb_wb), 0);
    end
    drive(SW, 1, 2, 0, 0);
    tick();
    chk("mw resume exmem", int'(exmem_m), 3'b010);
    chk("mw resume idex sw", int'(idex_ex), 5'b00001);
    tick();
    chk("mw resume memwb", int'(memwb_wb), 2'b11);

    // Illegal opcodes
    do_reset();
    drive(BAD, 0, 0, 0, 0);
    tick();
    drive(R, 0, 0, 0, 0);
    chk("ill 3f pulse", int'(illegal_op), 1);
    chk("ill 3f ctrl", int'(idex_ex), 0);
    tick();
    chk("ill 3f end", int'(illegal_op), 0);
    drive(ADDI, 0, 0, 0, 0);
    tick();
    drive(R, 0, 0, 0, 0);
    chk("ill addi pulse", int'(illegal_op), 1);
    chk("ill addi ctrl", int'(idex_ex), 0);
    tick();
    chk("ill addi end", int'(illegal_op), 0);

    // Counter saturation and asynchronous clear
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      drive(LW, 0, 2, 0, 0);
      tick();
      drive(R, 2, 0, 0, 0);
      tick();
    end
    chk("sat cnt", int'(stall_cnt), CNT_MAX);
    drive(LW, 0, 2, 0, 0);
    tick();
    drive(R, 2, 0, 0, 0);
    chk("sat stall pc_write", int'(pc_write), 0);
    rst_n = 1'b0;
    #1;
    chk("async clear cnt", int'(stall_cnt), 0);
    chk("async clear pc_write", int'(pc_write), 1);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] o;
      case ($urandom_range(0, 6))
        0: o = R;
        1: o = LW;
        2: o = SW;
        3: o = BEQ;
        4: o = ADDI;
        5: o = BAD;
        default: o = 6'($urandom);
      endcase
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        drive(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
      end else begin
        rst_n = 1'b1;
        drive(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
